serial_adder_ctrl: RTL and testbench

- Sequencer for a single 1-bit full-adder cell: performs a W-bit add bit-serially, LSB first, one bit per clock.
- Operands are accepted via a valid/ready handshake; the result is returned via a second valid/ready handshake.
- Area-optimised alternative to a W-bit ripple adder, for low-throughput arithmetic paths in the datapath.

---
 rtl/serial_adder_pkg.sv | 7 +
 rtl/serial_fa_cell.sv | 11 +
 rtl/serial_adder_ctrl.sv | 70 +++++++
 tb/tb_serial_adder_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM states and counter sizing shared by the serial adder blocks
package serial_adder_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: combinational 1-bit full adder
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial W-bit adder sequencer, LSB first; SERIAL_ADDER_SUB_EN adds sub_i
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub_i,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum_o,
  output logic         co_o,
  output logic         busy
);
  localparam int CW = cnt_w(W);
  state_t         state, state_nxt;
  logic [CW-1:0]  count;
  logic [W-1:0]   a_sr, b_sr, sum_r;
  logic           carry, s, co, sub, accept;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub = sub_i;
`else
  assign sub = 1'b0;
`endif
  serial_fa_cell u_cell (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(s), .co(co));
  always_comb begin
    in_ready  = state == ST_IDLE;
    out_valid = state == ST_DONE;
    busy      = state == ST_RUN || state == ST_DONE;
    accept    = in_valid && in_ready;
    state_nxt = state == ST_IDLE ? (in_valid ? ST_RUN : ST_IDLE) :
                state == ST_RUN  ? (count == CW'(W - 1) ? ST_DONE : ST_RUN) :
                state == ST_DONE ? (out_ready ? ST_IDLE : ST_DONE) : ST_IDLE;
  end
  // the result fills from the MSB so it is aligned after exactly W shifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      sum_r <= '0;
      carry <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sr  <= a_i;
        b_sr  <= sub ? ~b_i : b_i;
        carry <= sub ? 1'b1 : c_i;
        count <= '0;
      end else if (state == ST_RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        sum_r <= {s, sum_r[W-1:1]};
        carry <= co;
        count <= count + 1'b1;
      end
    end
  end
  assign sum_o = sum_r;
  assign co_o  = carry;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized self-checking bench against an arithmetic reference model
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, c_i = 1'b0, sub_i = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         in_ready, out_valid, co_o, busy;
  logic [W-1:0] sum_o;
  int           checks = 0, failures = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_i(a_i), .b_i(b_i), .c_i(c_i),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i(sub_i),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum_o(sum_o), .co_o(co_o), .busy(busy)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic sub);
    return sub ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1)) : ({1'b0, a} + {1'b0, b} + (W+1)'(c));
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic sub,
                        output logic [W-1:0] s, output logic co, output int lat, output int low);
    @(negedge clk);
    a_i = a; b_i = b; c_i = c; sub_i = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; lat = 0; low = 0;
    while (!out_valid && lat < W + 20) begin
      if (!in_ready) low++;
      @(negedge clk);
      lat++;
    end
    if (!in_ready) low++;
    s = sum_o; co = co_o;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (sum_o !== '0) begin failures++; $display("FAIL reset_sum: got %h expected 00", sum_o); end
    if (co_o !== 1'b0) begin failures++; $display("FAIL reset_co: got %b expected 0", co_o); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic co; int lat, low;
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, s, co, lat, low);
    checks += 4;
    if (lat !== W) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", lat, W); end
    if (s !== 8'h8D) begin failures++; $display("FAIL basic_sum: got %h expected 8d", s); end
    if (co !== 1'b0) begin failures++; $display("FAIL basic_co: got %b expected 0", co); end
    if (low !== W + 1) begin failures++; $display("FAIL basic_in_ready_low: got %0d expected %0d", low, W + 1); end
  endtask

  task automatic test_carry();
    logic [W-1:0] s; logic co; int lat, low;
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, s, co, lat, low);
    checks += 2;
    if (s !== 8'h00) begin failures++; $display("FAIL carry1_sum: got %h expected 00", s); end
    if (co !== 1'b1) begin failures++; $display("FAIL carry1_co: got %b expected 1", co); end
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, s, co, lat, low);
    checks += 2;
    if (s !== 8'hFF) begin failures++; $display("FAIL carry2_sum: got %h expected ff", s); end
    if (co !== 1'b1) begin failures++; $display("FAIL carry2_co: got %b expected 1", co); end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    a_i = 8'h12; b_i = 8'h34; c_i = 1'b0; sub_i = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    a_i = 8'hAA; b_i = 8'h55;
    n = 0;
    while (!out_valid && n < W + 20) begin @(negedge clk); n++; end
    checks++;
    if (n !== W) begin failures++; $display("FAIL bp_latency: got %0d expected %0d", n, W); end
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid: got %b expected 1", out_valid); end
      if (sum_o !== 8'h46 || co_o !== 1'b0) begin failures++; $display("FAIL bp_hold_result: got %b_%h expected 0_46", co_o, sum_o); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks += 2;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_idle_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < W + 20) begin @(negedge clk); n++; end
    checks++;
    if ({co_o, sum_o} !== model(8'hAA, 8'h55, 1'b0, 1'b0)) begin
      failures++; $display("FAIL bp_next_result: got %h expected %h", {co_o, sum_o}, model(8'hAA, 8'h55, 1'b0, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s; logic co; int lat, low; bit seen;
    @(negedge clk);
    a_i = 8'h5A; b_i = 8'hC3; c_i = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    if (sum_o !== '0) begin failures++; $display("FAIL rstmid_sum: got %h expected 00", sum_o); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_release_ready: got %b expected 1", in_ready); end
    seen = 1'b0;
    repeat (W + 2) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("FAIL rstmid_ghost_valid: got 1 expected 0"); end
    run_op(8'h01, 8'h01, 1'b0, 1'b0, s, co, lat, low);
    checks += 2;
    if (s !== 8'h02) begin failures++; $display("FAIL rstmid_next_sum: got %h expected 02", s); end
    if (co !== 1'b0) begin failures++; $display("FAIL rstmid_next_co: got %b expected 0", co); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa[3], ob[3]; logic oc[3];
    logic [W:0] got[$];
    int acc[3]; int k, cyc;
    for (int i = 0; i < 3; i++) begin
      oa[i] = W'($urandom); ob[i] = W'($urandom); oc[i] = 1'($urandom);
    end
    @(negedge clk);
    a_i = oa[0]; b_i = ob[0]; c_i = oc[0]; sub_i = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    k = 0; cyc = 0;
    while (got.size() < 3 && cyc < 80) begin
      if (out_valid) got.push_back({co_o, sum_o});
      if (in_valid && in_ready) begin acc[k] = cyc; k++; end
      @(negedge clk);
      cyc++;
      if (k < 3) begin a_i = oa[k]; b_i = ob[k]; c_i = oc[k]; end
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() !== 3 || k !== 3) begin
      failures++; $display("FAIL b2b_count: got %0d results %0d accepts expected 3", got.size(), k);
    end else begin
      checks += 2;
      if (acc[1] - acc[0] !== W + 2) begin failures++; $display("FAIL b2b_spacing01: got %0d expected %0d", acc[1] - acc[0], W + 2); end
      if (acc[2] - acc[1] !== W + 2) begin failures++; $display("FAIL b2b_spacing12: got %0d expected %0d", acc[2] - acc[1], W + 2); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== model(oa[i], ob[i], oc[i], 1'b0)) begin
          failures++; $display("FAIL b2b_result%0d: got %h expected %h", i, got[i], model(oa[i], ob[i], oc[i], 1'b0));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s; logic c, sb, co; int lat, low;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      run_op(a, b, c, sb, s, co, lat, low);
      checks += 2;
      if (lat !== W) begin failures++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, W); end
      if ({co, s} !== model(a, b, c, sb)) begin
        failures++; $display("FAIL rand%0d_result: a=%h b=%h c=%b sub=%b got %h expected %h", i, a, b, c, sb, {co, s}, model(a, b, c, sb));
      end
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [W-1:0] s; logic co; int lat, low;
    run_op(8'h10, 8'h01, 1'b0, 1'b1, s, co, lat, low);
    checks += 2;
    if (s !== 8'h0F) begin failures++; $display("FAIL sub1_sum: got %h expected 0f", s); end
    if (co !== 1'b1) begin failures++; $display("FAIL sub1_co: got %b expected 1", co); end
    run_op(8'h01, 8'h02, 1'b0, 1'b1, s, co, lat, low);
    checks += 2;
    if (s !== 8'hFF) begin failures++; $display("FAIL sub2_sum: got %h expected ff", s); end
    if (co !== 1'b0) begin failures++; $display("FAIL sub2_co: got %b expected 0", co); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
